// File: rtl/syscall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : syscall_ctrl_pkg
// Description : Shared defines for the SYSCALL controller: FSM state
//               encodings, PC increment stop mask and the exit service code.
// Revision    : 1.0 - initial release
// ============================================================================
package syscall_ctrl_pkg;

    // FSM state encoding (explicit width, legacy-compatible constants)
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_DISPLAY = 2'd1;
    localparam state_t ST_RELEASE = 2'd2;
    localparam state_t ST_HALT    = 2'd3;

    // OR-mask forcing the PC increment select to its "hold" encoding
    localparam logic [1:0]  PC_INC_STOP_OR_MASK = 2'b11;

    // $v0 service number that terminates the program
    localparam logic [31:0] SYSCALL_EXIT = 32'd10;

    // True when the $v0 service code requests program exit
    function automatic logic is_exit(input logic [31:0] v0);
        return (v0 == SYSCALL_EXIT);
    endfunction

endpackage : syscall_ctrl_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at its all-ones value instead of
//               wrapping. Asynchronous active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] c_max = '1;

    logic [WIDTH-1:0] r_count;

    // Count increment requests, holding at the maximum value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != c_max)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/syscall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : syscall_ctrl
// Description : SYSCALL handler for the EX stage. Prints $a0 through a
//               valid/ready display port (with optional timeout), or halts the
//               CPU on the exit service until a debug resume. Stalls the
//               front of the pipeline while a syscall is being serviced.
// Revision    : 1.0 - initial release
// ============================================================================
module syscall_ctrl
    import syscall_ctrl_pkg::*;
#(
    parameter int DISP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        syscall_ex,
    input  logic [31:0] reg_v0,
    input  logic [31:0] reg_a0,
    input  logic        disp_ready,
    input  logic        resume,
    output logic        disp_valid,
    output logic [31:0] disp_data,
    output logic        stall,
    output logic [1:0]  pc_inc_mask,
    output logic        halted,
    output logic        disp_dropped,
    output logic [15:0] syscall_count
);

    // Timeout fires when the counter reaches DISP_TIMEOUT-1; zero disables it
    localparam logic       c_timeout_en   = (DISP_TIMEOUT != 0);
    localparam logic [7:0] c_timeout_last = 8'(DISP_TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_disp_data;
    logic [7:0]  r_tmo_cnt;
    logic        r_dropped;

    logic        w_accept;
    logic        w_in_display;
    logic        w_timeout;

    // A syscall is only taken from IDLE; RELEASE deliberately ignores it
    assign w_accept     = (r_state == ST_IDLE) && syscall_ex;
    assign w_in_display = (r_state == ST_DISPLAY);
    assign w_timeout    = w_in_display && c_timeout_en && (r_tmo_cnt == c_timeout_last);

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (syscall_ex) begin
                    w_next_state = is_exit(reg_v0) ? ST_HALT : ST_DISPLAY;
                end
            end
            ST_DISPLAY: begin
                if (disp_ready || w_timeout) begin
                    w_next_state = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                w_next_state = ST_IDLE;
            end
            ST_HALT: begin
                if (resume) begin
                    w_next_state = ST_RELEASE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture $a0 when a print syscall is accepted; held through DISPLAY
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_disp_data <= '0;
        end else if (w_accept && !is_exit(reg_v0)) begin
            r_disp_data <= reg_a0;
        end
    end

    // Display wait counter: cleared on acceptance, counts unanswered cycles
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_tmo_cnt <= '0;
        end else if (w_accept) begin
            r_tmo_cnt <= '0;
        end else if (w_in_display && !disp_ready) begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
        end
    end

    // Sticky drop flag; a same-cycle handshake takes priority over timeout
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_dropped <= 1'b0;
        end else if (w_timeout && !disp_ready) begin
            r_dropped <= 1'b1;
        end
    end

    sat_counter #(
        .WIDTH (16)
    ) u_sat_counter (
        .clk     (clk),
        .rst     (clr),
        .i_inc   (w_accept),
        .o_count (syscall_count)
    );

    // Outputs decoded from the registered state so reset clears them at once
    assign disp_valid   = w_in_display;
    assign disp_data    = r_disp_data;
    assign halted       = (r_state == ST_HALT);
    assign pc_inc_mask  = (r_state == ST_HALT) ? PC_INC_STOP_OR_MASK : 2'b00;
    assign disp_dropped = r_dropped;
    assign stall        = w_accept || w_in_display || (r_state == ST_HALT);

endmodule : syscall_ctrl
`default_nettype wire

// File: tb/tb_syscall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_syscall_ctrl
// Description : Self-checking bench for syscall_ctrl (DISP_TIMEOUT = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_syscall_ctrl;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        clr;
    logic        syscall_ex;
    logic [31:0] reg_v0;
    logic [31:0] reg_a0;
    logic        disp_ready;
    logic        resume;
    logic        disp_valid;
    logic [31:0] disp_data;
    logic        stall;
    logic [1:0]  pc_inc_mask;
    logic        halted;
    logic        disp_dropped;
    logic [15:0] syscall_count;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_xfer  = 0;
    logic [31:0] obs_q[$];
    int          exp_count   = 0;
    logic        exp_dropped = 1'b0;

    always #5 clk = ~clk;

    syscall_ctrl #(
        .DISP_TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .clr           (clr),
        .syscall_ex    (syscall_ex),
        .reg_v0        (reg_v0),
        .reg_a0        (reg_a0),
        .disp_ready    (disp_ready),
        .resume        (resume),
        .disp_valid    (disp_valid),
        .disp_data     (disp_data),
        .stall         (stall),
        .pc_inc_mask   (pc_inc_mask),
        .halted        (halted),
        .disp_dropped  (disp_dropped),
        .syscall_count (syscall_count)
    );

    // Record every completed display transfer
    always @(posedge clk) begin
        if (disp_valid === 1'b1 && disp_ready === 1'b1) begin
            n_xfer++;
            obs_q.push_back(disp_data);
        end
    end

    // Print syscall; ready_at = display cycle (1-based) raising disp_ready, 0 = never.
    // Returns at negedge+1 of the first unstalled cycle after acceptance.
    task automatic drive_print(input logic [31:0] v0, input logic [31:0] a0, input int ready_at,
                               output int stall_cyc, output int valid_cyc,
                               output bit data_ok, output bit released);
        stall_cyc = 0; valid_cyc = 0; data_ok = 1'b1; released = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            syscall_ex = (k == 0);
            reg_v0     = (k == 0) ? v0 : $urandom;
            reg_a0     = (k == 0) ? a0 : $urandom;
            disp_ready = (k > 0) && (k == ready_at);
            #1;
            if (stall === 1'b1) stall_cyc++;
            if (disp_valid === 1'b1) begin
                valid_cyc++;
                if (disp_data !== a0) data_ok = 1'b0;
            end
            if (k > 0 && stall === 1'b0) begin
                released = 1'b1;
                break;
            end
        end
        disp_ready = 1'b0;
    endtask

    // Exit syscall held in HALT for len cycles, then resumed
    task automatic drive_exit(input int len, output bit halt_ok, output bit rel_ok);
        @(negedge clk);
        syscall_ex = 1'b1; reg_v0 = 32'd10; reg_a0 = $urandom; disp_ready = 1'b0; resume = 1'b0;
        #1;
        halt_ok = (stall === 1'b1) && (halted === 1'b0);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            disp_ready = 1'($urandom_range(0, 1));
            #1;
            if (!(halted === 1'b1 && pc_inc_mask === 2'b11 && stall === 1'b1 && disp_valid === 1'b0))
                halt_ok = 1'b0;
        end
        @(negedge clk);
        disp_ready = 1'b0; resume = 1'b1;
        #1;
        if (halted !== 1'b1) halt_ok = 1'b0;
        @(negedge clk);
        resume = 1'b0; syscall_ex = 1'b0;
        #1;
        rel_ok = (halted === 1'b0) && (stall === 1'b0) && (pc_inc_mask === 2'b00) && (disp_valid === 1'b0);
    endtask

    task automatic test_reset();
        clr = 1'b1; syscall_ex = 1'b0; reg_v0 = '0; reg_a0 = '0; disp_ready = 1'b0; resume = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if ({disp_valid, disp_data, pc_inc_mask, halted, disp_dropped, syscall_count, stall} !== 54'd0) begin
            n_fail++;
            $display("FAIL reset_values: got valid=%b data=%h mask=%b halted=%b dropped=%b count=%0d stall=%b, expected all 0",
                     disp_valid, disp_data, pc_inc_mask, halted, disp_dropped, syscall_count, stall);
        end
        syscall_ex = 1'b1;
        #1;
        n_tests++;
        if (stall !== 1'b1) begin
            n_fail++; $display("FAIL reset_stall_follow_hi: got %b expected 1", stall);
        end
        syscall_ex = 1'b0;
        #1;
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall_follow_lo: got %b expected 0", stall);
        end
        @(negedge clk);
        clr = 1'b0;
        exp_count = 0; exp_dropped = 1'b0;
    endtask

    task automatic test_print();
        int sc, vc; bit ok, rel; int base; logic [31:0] d;
        base = n_xfer;
        drive_print(32'd1, 32'h0000002A, 2, sc, vc, ok, rel);
        exp_count++;
        n_tests++;
        if (sc != 3 || vc != 2 || !ok || !rel) begin
            n_fail++; $display("FAIL print_shape: stall=%0d valid=%0d data_ok=%0d released=%0d expected 3 2 1 1", sc, vc, ok, rel);
        end
        n_tests++;
        if (n_xfer - base != 1 || obs_q.size() == 0) begin
            n_fail++; $display("FAIL print_xfers: got %0d expected 1", n_xfer - base);
        end else begin
            d = obs_q.pop_front();
            n_tests++;
            if (d !== 32'h2A) begin
                n_fail++; $display("FAIL print_data: got %h expected 0000002a", d);
            end
        end
        n_tests++;
        if (syscall_count !== 16'(exp_count)) begin
            n_fail++; $display("FAIL print_count: got %0d expected %0d", syscall_count, exp_count);
        end
    endtask

    task automatic test_exit();
        bit hok, rok;
        drive_exit(20, hok, rok);
        exp_count++;
        n_tests++;
        if (!hok) begin n_fail++; $display("FAIL exit_halt_hold: got 0 expected 1"); end
        n_tests++;
        if (!rok) begin n_fail++; $display("FAIL exit_release: got halted=%b stall=%b expected 0 0", halted, stall); end
        @(negedge clk);
        resume = 1'b1; // resume outside HALT must be ignored
        #1;
        n_tests++;
        if (halted !== 1'b0 || stall !== 1'b0 || syscall_count !== 16'(exp_count)) begin
            n_fail++; $display("FAIL exit_idle: got halted=%b stall=%b count=%0d expected 0 0 %0d", halted, stall, syscall_count, exp_count);
        end
        @(negedge clk);
        resume = 1'b0;
        #1;
        n_tests++;
        if (halted !== 1'b0) begin n_fail++; $display("FAIL resume_ignored: got halted=%b expected 0", halted); end
    endtask

    task automatic test_timeout();
        int sc, vc; bit ok, rel; int base; logic [31:0] d;
        base = n_xfer;
        drive_print(32'd4, 32'h12345678, 0, sc, vc, ok, rel);
        exp_count++; exp_dropped = 1'b1;
        n_tests++;
        if (vc != TMO || sc != TMO + 1 || !rel || n_xfer != base) begin
            n_fail++; $display("FAIL timeout_shape: valid=%0d stall=%0d rel=%0d xfers=%0d expected 4 5 1 0", vc, sc, rel, n_xfer - base);
        end
        n_tests++;
        if (disp_dropped !== 1'b1) begin n_fail++; $display("FAIL timeout_dropped: got %b expected 1", disp_dropped); end
        drive_print(32'd1, 32'h00000077, 1, sc, vc, ok, rel);
        exp_count++;
        n_tests++;
        if (n_xfer - base != 1 || obs_q.size() == 0) begin
            n_fail++; $display("FAIL timeout_next_xfer: got %0d expected 1", n_xfer - base);
        end else begin
            d = obs_q.pop_front();
            n_tests++;
            if (d !== 32'h77) begin n_fail++; $display("FAIL timeout_next_data: got %h expected 00000077", d); end
        end
        n_tests++;
        if (disp_dropped !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b expected 1", disp_dropped); end
    endtask

    task automatic test_timeout_handshake();
        int sc, vc; bit ok, rel; int base; logic [31:0] d;
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        exp_count = 0; exp_dropped = 1'b0;
        base = n_xfer;
        drive_print(32'd1, 32'hCAFEF00D, TMO, sc, vc, ok, rel);
        exp_count++;
        n_tests++;
        if (vc != TMO || n_xfer - base != 1 || obs_q.size() == 0) begin
            n_fail++; $display("FAIL tie_xfer: valid=%0d xfers=%0d expected 4 1", vc, n_xfer - base);
        end else begin
            d = obs_q.pop_front();
            n_tests++;
            if (d !== 32'hCAFEF00D) begin n_fail++; $display("FAIL tie_data: got %h expected cafef00d", d); end
        end
        n_tests++;
        if (disp_dropped !== 1'b0) begin n_fail++; $display("FAIL tie_dropped: got %b expected 0", disp_dropped); end
    endtask

    task automatic test_mid_reset();
        int base;
        base = n_xfer;
        @(negedge clk);
        syscall_ex = 1'b1; reg_v0 = 32'd1; reg_a0 = 32'hDEADBEEF; disp_ready = 1'b0;
        @(negedge clk);
        syscall_ex = 1'b0;
        #1;
        n_tests++;
        if (disp_valid !== 1'b1 || disp_data !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL midrst_pre: got valid=%b data=%h expected 1 deadbeef", disp_valid, disp_data);
        end
        clr = 1'b1;
        #1;
        disp_ready = 1'b1;
        n_tests++;
        if (disp_valid !== 1'b0 || disp_data !== 32'd0 || syscall_count !== 16'd0) begin
            n_fail++; $display("FAIL midrst_display: got valid=%b data=%h count=%0d expected 0 0 0", disp_valid, disp_data, syscall_count);
        end
        @(negedge clk);
        disp_ready = 1'b0;
        // first edge after reset release must evaluate IDLE
        clr = 1'b0; syscall_ex = 1'b1; reg_v0 = 32'd10;
        @(negedge clk);
        #1;
        n_tests++;
        if (n_xfer != base || halted !== 1'b1 || syscall_count !== 16'd1) begin
            n_fail++; $display("FAIL midrst_restart: got xfers=%0d halted=%b count=%0d expected 0 1 1", n_xfer - base, halted, syscall_count);
        end
        clr = 1'b1;
        #1;
        n_tests++;
        if (halted !== 1'b0 || pc_inc_mask !== 2'b00 || stall !== 1'b1) begin
            n_fail++; $display("FAIL midrst_halt: got halted=%b mask=%b stall=%b expected 0 00 1", halted, pc_inc_mask, stall);
        end
        @(negedge clk);
        clr = 1'b0; syscall_ex = 1'b0;
        exp_count = 0; exp_dropped = 1'b0;
    endtask

    task automatic test_back_to_back();
        int base; logic [31:0] a_first; logic [31:0] d0; logic [31:0] d1; bit ok;
        base = n_xfer; ok = 1'b1;
        a_first = $urandom;
        @(negedge clk);
        syscall_ex = 1'b1; reg_v0 = 32'd1; reg_a0 = a_first; disp_ready = 1'b0;
        @(negedge clk);
        disp_ready = 1'b1;
        #1;
        if (disp_valid !== 1'b1 || disp_data !== a_first) ok = 1'b0;
        @(negedge clk);
        disp_ready = 1'b0; syscall_ex = 1'b1; reg_v0 = 32'd1; reg_a0 = 32'd5;
        #1;
        n_tests++;
        if (stall !== 1'b0 || disp_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_release: got stall=%b valid=%b expected 0 0", stall, disp_valid);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (stall !== 1'b1 || disp_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_second_accept: got stall=%b valid=%b expected 1 0", stall, disp_valid);
        end
        @(negedge clk);
        syscall_ex = 1'b0; disp_ready = 1'b1;
        #1;
        if (disp_valid !== 1'b1 || disp_data !== 32'd5) ok = 1'b0;
        @(negedge clk);
        disp_ready = 1'b0;
        #1;
        if (stall !== 1'b0) ok = 1'b0;
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL b2b_sequence: got 0 expected 1"); end
        n_tests++;
        if (n_xfer - base != 2 || obs_q.size() < 2 || syscall_count !== 16'd2) begin
            n_fail++; $display("FAIL b2b_xfers: got xfers=%0d count=%0d expected 2 2", n_xfer - base, syscall_count);
        end else begin
            d0 = obs_q.pop_front();
            d1 = obs_q.pop_front();
            n_tests++;
            if (d0 !== a_first || d1 !== 32'd5) begin
                n_fail++; $display("FAIL b2b_data: got %h %h expected %h 00000005", d0, d1, a_first);
            end
        end
        exp_count = 2;
    endtask

    task automatic test_random();
        int sc, vc, base, ready_at, exp_vc, gap; bit ok, rel, xfer, idle_ok, hok, rok;
        logic [31:0] a0, v0, d;
        for (int it = 0; it < 40; it++) begin
            gap = $urandom_range(0, 2);
            idle_ok = 1'b1;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                syscall_ex = 1'b0; disp_ready = 1'($urandom_range(0, 1)); resume = 1'($urandom_range(0, 1));
                #1;
                if (stall !== 1'b0 || disp_valid !== 1'b0 || halted !== 1'b0 || pc_inc_mask !== 2'b00) idle_ok = 1'b0;
            end
            disp_ready = 1'b0; resume = 1'b0;
            n_tests++;
            if (!idle_ok) begin n_fail++; $display("FAIL rnd_idle it=%0d: got busy expected idle", it); end
            if ($urandom_range(0, 3) == 0) begin
                drive_exit($urandom_range(1, 6), hok, rok);
                exp_count++;
                n_tests++;
                if (!hok || !rok) begin n_fail++; $display("FAIL rnd_exit it=%0d: got halt=%0d rel=%0d expected 1 1", it, hok, rok); end
            end else begin
                a0 = $urandom; v0 = $urandom;
                if (v0 == 32'd10) v0 = 32'd11;
                ready_at = $urandom_range(0, 6);
                base = n_xfer;
                drive_print(v0, a0, ready_at, sc, vc, ok, rel);
                xfer   = (ready_at >= 1) && (ready_at <= TMO);
                exp_vc = xfer ? ready_at : TMO;
                exp_count++;
                if (!xfer) exp_dropped = 1'b1;
                n_tests++;
                if (vc != exp_vc || sc != exp_vc + 1 || !ok || !rel || (n_xfer - base) != int'(xfer)) begin
                    n_fail++;
                    $display("FAIL rnd_print it=%0d: got valid=%0d stall=%0d ok=%0d rel=%0d xfers=%0d expected %0d %0d 1 1 %0d",
                             it, vc, sc, ok, rel, n_xfer - base, exp_vc, exp_vc + 1, xfer);
                end else if (xfer) begin
                    d = obs_q.pop_front();
                    n_tests++;
                    if (d !== a0) begin n_fail++; $display("FAIL rnd_data it=%0d: got %h expected %h", it, d, a0); end
                end
            end
            n_tests++;
            if (disp_dropped !== exp_dropped || syscall_count !== 16'(exp_count)) begin
                n_fail++;
                $display("FAIL rnd_state it=%0d: got dropped=%b count=%0d expected %b %0d",
                         it, disp_dropped, syscall_count, exp_dropped, exp_count);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_print();
        test_exit();
        test_timeout();
        test_timeout_handshake();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_syscall_ctrl
`default_nettype wire

// File: doc/syscall_ctrl.md
SYSCALL_CTRL -- requirements
Module: syscall_ctrl

Interface
REQ-001 The block SHALL have parameter DISP_TIMEOUT, default 255, which sets the cycles DISPLAY waits for disp_ready (0 = wait forever).
REQ-002 The block SHALL have port clk, in, 1: global clock; all state updates on posedge.
REQ-003 The block SHALL have port clr, in, 1: global reset, asynchronous and active-high.
REQ-004 The block SHALL have port syscall_ex, in, 1: the instruction currently in EX is SYSCALL (opcode 0, funct SYSCALL).
REQ-005 The block SHALL have port reg_v0, in, 32: $v0 value for the EX-stage syscall.
REQ-006 The block SHALL have port reg_a0, in, 32: $a0 value for the EX-stage syscall.
REQ-007 The block SHALL have port disp_ready, in, 1: the display sink accepts disp_data.
REQ-008 The block SHALL have port resume, in, 1: a debug request to leave HALT.
REQ-009 The block SHALL have port disp_valid, out, 1: disp_data is valid.
REQ-010 The block SHALL have port disp_data, out, 32: the latched $a0.
REQ-011 The block SHALL have port stall, out, 1: freeze IF/ID/EX latches and PC.
REQ-012 The block SHALL have port pc_inc_mask, out, 2: OR-mask applied to the PC increment select.
REQ-013 The block SHALL have port halted, out, 1: the CPU is stopped by syscall 10.
REQ-014 The block SHALL have port disp_dropped, out, 1: sticky flag, a display timed out.
REQ-015 The block SHALL have port syscall_count, out, 16: accepted syscalls, saturating.

Function
REQ-016 The FSM SHALL have states IDLE, DISPLAY, RELEASE and HALT, all registered.
REQ-017 In IDLE with syscall_ex=1 and reg_v0==32'd10, the next state SHALL be HALT.
REQ-018 In IDLE with syscall_ex=1 and reg_v0!=10, the next state SHALL be DISPLAY, and disp_data SHALL be loaded with reg_a0 on the same edge.
REQ-019 stall SHALL be combinational: 1 when (state==IDLE and syscall_ex) or state is DISPLAY or HALT; 0 in RELEASE.
REQ-020 In DISPLAY, disp_valid SHALL be 1, and disp_data SHALL stay stable until the handshake completes.
REQ-021 disp_valid&&disp_ready at a posedge SHALL move DISPLAY to RELEASE, giving one transfer per syscall.
REQ-022 The 8-bit timeout counter SHALL be cleared on entry to DISPLAY and SHALL increment each DISPLAY cycle without a handshake.
REQ-023 When the timeout counter reaches DISP_TIMEOUT-1 without a handshake, the FSM SHALL move to RELEASE and set disp_dropped.
REQ-024 A handshake in the same cycle as the timeout SHALL win, and disp_dropped SHALL stay unchanged.
REQ-025 RELEASE SHALL last exactly one cycle with stall=0 and SHALL then return to IDLE.
REQ-026 syscall_ex SHALL be ignored during RELEASE, so the releasing syscall is not re-accepted.
REQ-027 In HALT, halted SHALL be 1, pc_inc_mask SHALL be PC_INC_STOP_OR_MASK, and stall SHALL be 1.
REQ-028 In all other states, pc_inc_mask SHALL be 2'b00 and halted SHALL be 0.
REQ-029 resume=1 in HALT SHALL move the FSM to RELEASE; resume SHALL be ignored in every other state.
REQ-030 syscall_count SHALL increment on each IDLE->DISPLAY and IDLE->HALT transition, saturating at 16'hFFFF.
REQ-031 disp_ready SHALL have no effect outside DISPLAY.

Reset
REQ-032 On clr=1, asynchronously: state=IDLE, disp_valid=0, disp_data=0, pc_inc_mask=0, halted=0, disp_dropped=0, syscall_count=0, timeout counter=0.
REQ-033 stall SHALL follow syscall_ex while clr=1.
REQ-034 Reset asserted mid-DISPLAY or mid-HALT SHALL drop disp_valid and halted in the same cycle, with no transfer.
REQ-035 After clr deasserts, the first posedge SHALL evaluate IDLE normally.

Structure
REQ-036 The state enum, PC_INC_STOP_OR_MASK (2'b11) and SYSCALL_EXIT (32'd10) SHALL live in the shared defines package.
REQ-037 The saturating 16-bit counter SHALL be a sub-module, sat_counter, parameterised by width.
REQ-038 The block SHALL have no other sub-modules, and an implementation of about 150-250 lines is expected.

Verification
REQ-039 The bench SHALL cover a print: syscall_ex=1, v0=1, a0=0x0000002A, disp_ready=1 on the 2nd DISPLAY cycle -> disp_data=0x2A, disp_valid for 2 cycles, stall high 3 cycles, 1 RELEASE cycle, syscall_count=1.
REQ-040 The bench SHALL cover an exit: syscall_ex=1, v0=10 -> halted=1, pc_inc_mask=2'b11 from the next cycle and held for 20 cycles; then resume=1 -> RELEASE, then IDLE, with halted=0.
REQ-041 The bench SHALL cover a timeout: DISP_TIMEOUT=4, disp_ready=0 -> RELEASE after 4 DISPLAY cycles, disp_dropped=1, and it stays 1 after a later successful print.
REQ-042 The bench SHALL cover a handshake in the same cycle as the timeout: DISP_TIMEOUT=4 and disp_ready rising on the 4th DISPLAY cycle -> transfer completes and disp_dropped=0.
REQ-043 The bench SHALL cover a mid-operation reset: clr pulsed during DISPLAY (a0=0xDEADBEEF) -> disp_valid=0 with no clock edge needed, and syscall_count=0.
REQ-044 The bench SHALL cover back-to-back syscalls (held syscall_ex across RELEASE, then a new syscall with v0=1, a0=5) -> exactly 2 transfers, and syscall_count=2.
